// File: rtl/mac_tx.sv
// mac_tx: Ethernet MAC transmit stage.
// Takes a pre-built frame byte stream (dest MAC, source MAC, type, payload) from the upper-layer
// mux. It adds preamble/SFD in front, appends the CRC-32 FCS, enforces the inter-frame gap and
// drives the GMII TX pins.
//
// Optional feature: define MAC_TX_PAD_EN to zero-pad frames shorter than 60 bytes (before FCS).
//
// Ports:
//   clk, rstn      clock (rising edge), synchronous active-low reset
//   mac_tx_req     level request from the upper-layer mux
//   mac_tx_ack     one-cycle acceptance pulse (high while in ACK)
//   frame_ready    upper layer has the frame ready
//   frame_data     frame byte stream
//   frame_end      one-cycle end marker, END_LAG cycles before the final byte
//   mac_data_req   one-cycle pulse starting the byte stream, DATA_LAT cycles ahead of byte 0
//   mac_send_end   one-cycle pulse once the frame and the IFG are complete
//   gmii_txd       GMII transmit data (registered)
//   gmii_tx_en     GMII transmit enable (registered)
module mac_tx #(
  parameter int unsigned DATA_LAT   = 2,
  parameter int unsigned END_LAG    = 1,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MAX_FRAME  = 1514,
  parameter logic [15:0] TIMEOUT    = 16'hffff
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       mac_tx_req,
  output logic       mac_tx_ack,
  input  logic       frame_ready,
  input  logic [7:0] frame_data,
  input  logic       frame_end,
  output logic       mac_data_req,
  output logic       mac_send_end,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en
);

  localparam logic [31:0] CrcPoly = 32'hEDB88320;
  // Pulse index chosen so byte 0 lands on gmii_txd right after the SFD.
  localparam logic [15:0] ReqIdx  = 16'(8 - DATA_LAT);
  localparam logic [15:0] IfgLast = 16'(IFG_CYCLES - 1);
  localparam logic [15:0] TmoLast = TIMEOUT - 16'd1;
  localparam logic [10:0] MaxLast = 11'(MAX_FRAME - 1);
`ifdef MAC_TX_PAD_EN
  localparam logic [10:0] PadLast = 11'd59;
`endif

  typedef enum logic [2:0] {
    StIdle, StAck, StWaitReady, StPreamble, StData, StFcs, StIfg, StEnd
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] step_q, step_d;  // position inside PREAMBLE, FCS or IFG
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        end_seen_q, end_seen_d;
  logic [1:0]  lag_q, lag_d;    // remaining END_LAG cycles after frame_end
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_d;
  logic        tx_en_d;
  logic        send_end_d;
  logic [7:0]  tx_byte;
  logic [31:0] fcs;
  logic        data_last;
`ifdef MAC_TX_PAD_EN
  logic        pad_q, pad_d;
`endif

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ b[i]) ? CrcPoly : 32'h0);
    end
    return c;
  endfunction

  assign fcs = ~crc_q;

  // Final frame byte: frame_end with no lag, or the lag has run out.
  assign data_last = (frame_end && !end_seen_q && (END_LAG == 0)) ||
                     (end_seen_q && (lag_q == 2'd1));

  always_comb begin
    state_d      = state_q;
    tmo_d        = '0;
    step_d       = step_q;
    byte_cnt_d   = byte_cnt_q;
    end_seen_d   = end_seen_q;
    lag_d        = lag_q;
    crc_d        = crc_q;
    txd_d        = '0;
    tx_en_d      = 1'b0;
    send_end_d   = 1'b0;
    mac_tx_ack   = 1'b0;
    mac_data_req = 1'b0;
    tx_byte      = frame_data;
`ifdef MAC_TX_PAD_EN
    pad_d        = pad_q;
    if (pad_q) tx_byte = 8'h00;
`endif

    // frame_end may arrive before DATA starts when the frame is short.
    if ((state_q == StPreamble || state_q == StData) && frame_end && !end_seen_q) begin
      end_seen_d = 1'b1;
      lag_d      = 2'(END_LAG);
    end else if (end_seen_q && lag_q != 2'd0) begin
      lag_d = lag_q - 2'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (mac_tx_req) state_d = StAck;
      end
      StAck: begin
        mac_tx_ack = 1'b1;
        crc_d      = '1;
        byte_cnt_d = '0;
        end_seen_d = 1'b0;
        lag_d      = '0;
        step_d     = '0;
`ifdef MAC_TX_PAD_EN
        pad_d      = 1'b0;
`endif
        state_d    = StWaitReady;
      end
      StWaitReady: begin
        if (frame_ready) begin
          state_d = StPreamble;
          step_d  = '0;
        end else if (tmo_q >= TmoLast) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StPreamble: begin
        tx_en_d      = 1'b1;
        txd_d        = (step_q == 16'd7) ? 8'hD5 : 8'h55;
        mac_data_req = (step_q == ReqIdx);
        if (step_q == 16'd7) begin
          state_d = StData;
          step_d  = '0;
        end else begin
          step_d = step_q + 16'd1;
        end
      end
      StData: begin
        tx_en_d = 1'b1;
        txd_d   = tx_byte;
        crc_d   = crc_step(crc_q, tx_byte);
        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 11'd1;
        if (byte_cnt_q >= MaxLast) begin
          state_d = StFcs;
          step_d  = '0;
        end
`ifdef MAC_TX_PAD_EN
        else if (pad_q) begin
          if (byte_cnt_q >= PadLast) begin
            state_d = StFcs;
            step_d  = '0;
          end
        end else if (data_last) begin
          if (byte_cnt_q < PadLast) begin
            pad_d = 1'b1;
          end else begin
            state_d = StFcs;
            step_d  = '0;
          end
        end
`else
        else if (data_last) begin
          state_d = StFcs;
          step_d  = '0;
        end
`endif
      end
      StFcs: begin
        tx_en_d = 1'b1;
        txd_d   = fcs[{step_q[1:0], 3'b000} +: 8];
        if (step_q == 16'd3) begin
          state_d = StIfg;
          step_d  = '0;
        end else begin
          step_d = step_q + 16'd1;
        end
      end
      StIfg: begin
        if (step_q >= IfgLast) begin
          state_d = StEnd;
        end else begin
          step_d = step_q + 16'd1;
        end
      end
      StEnd: begin
        send_end_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      tmo_q        <= '0;
      step_q       <= '0;
      byte_cnt_q   <= '0;
      end_seen_q   <= 1'b0;
      lag_q        <= '0;
      crc_q        <= 32'hffffffff;
      gmii_txd     <= '0;
      gmii_tx_en   <= 1'b0;
      mac_send_end <= 1'b0;
`ifdef MAC_TX_PAD_EN
      pad_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      step_q       <= step_d;
      byte_cnt_q   <= byte_cnt_d;
      end_seen_q   <= end_seen_d;
      lag_q        <= lag_d;
      crc_q        <= crc_d;
      gmii_txd     <= txd_d;
      gmii_tx_en   <= tx_en_d;
      mac_send_end <= send_end_d;
`ifdef MAC_TX_PAD_EN
      pad_q        <= pad_d;
`endif
    end
  end

endmodule

// File: tb/tb_mac_tx.sv
// tb_mac_tx: self-checking bench for mac_tx.
// A stimulus process plays the upper layer (req/ready/byte stream) and pushes the expected GMII
// byte sequence of each frame into a scoreboard. A separate monitor pops and compares every byte
// seen with gmii_tx_en high, and also checks frame length and the inter-frame gap.
module tb_mac_tx;
  localparam int DATA_LAT   = 2;
  localparam int END_LAG    = 1;
  localparam int IFG_CYCLES = 12;
  localparam int MAX_FRAME  = 1514;
  localparam int TIMEOUT    = 65535;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       mac_tx_req = 1'b0;
  logic       mac_tx_ack;
  logic       frame_ready = 1'b0;
  logic [7:0] frame_data = 8'h00;
  logic       frame_end = 1'b0;
  logic       mac_data_req;
  logic       mac_send_end;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;

  always #5 clk = ~clk;

  mac_tx #(
    .DATA_LAT  (DATA_LAT),
    .END_LAG   (END_LAG),
    .IFG_CYCLES(IFG_CYCLES),
    .MAX_FRAME (MAX_FRAME),
    .TIMEOUT   (16'hffff)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .mac_tx_req  (mac_tx_req),
    .mac_tx_ack  (mac_tx_ack),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_end   (frame_end),
    .mac_data_req(mac_data_req),
    .mac_send_end(mac_send_end),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  exp_q[$];
  int          exp_len_q[$];
  logic [31:0] crc_tab[256];
  bit          mon_en = 1'b0;
  int          mon_run = 0;
  int          mon_low = 0;
  bit          mon_after = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Byte-wise table-driven CRC-32 (reflected 0xEDB88320).
  function automatic void build_crc_tab();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
  endfunction

  function automatic void push_preamble();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
  endfunction

  // Expected GMII image of a frame: preamble, (truncated/padded) body, FCS LSB first.
  function automatic void push_expect(input logic [7:0] fr[$]);
    logic [7:0]  body[$];
    logic [31:0] crc;
    logic [31:0] f;
    body = {};
    foreach (fr[i]) if (i < MAX_FRAME) body.push_back(fr[i]);
`ifdef MAC_TX_PAD_EN
    while (body.size() < 60) body.push_back(8'h00);
`endif
    crc = 32'hffffffff;
    foreach (body[i]) crc = crc_tab[crc[7:0] ^ body[i]] ^ (crc >> 8);
    f = ~crc;
    push_preamble();
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
    exp_len_q.push_back(8 + body.size() + 4);
  endfunction

  // Monitor: compares GMII output against the scoreboard.
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_run = 0;
      mon_low = 0;
      mon_after = 1'b0;
    end else if (gmii_tx_en) begin
      if (mon_run == 0 && mon_after) check("ifg_gap_min", 32'(mon_low >= IFG_CYCLES), 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_tx_byte: got 0x%0h expected no byte at %0t", gmii_txd, $time);
      end else begin
        check("gmii_byte", {24'h0, gmii_txd}, {24'h0, exp_q.pop_front()});
      end
      mon_run++;
      mon_low = 0;
    end else begin
      if (mon_run > 0) begin
        if (exp_len_q.size() != 0) check("tx_en_length", mon_run, exp_len_q.pop_front());
        mon_run = 0;
        mon_after = 1'b1;
        mon_low = 0;
      end
      if (mac_send_end && mon_after) check("ifg_before_send_end", mon_low, IFG_CYCLES);
      if (gmii_txd != 8'h00) check("idle_txd_zero", {24'h0, gmii_txd}, 32'h0);
      mon_low++;
    end
  end

  task automatic wait_out(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < bound && !ok; t++) begin
      @(negedge clk);
      case (which)
        0:       ok = mac_tx_ack;
        1:       ok = mac_data_req;
        default: ok = mac_send_end;
      endcase
    end
  endtask

  // Plays one frame as the upper layer. Expectation must already be pushed.
  task automatic run_frame(input logic [7:0] fr[$], input int ready_dly, input bit keep_req);
    bit ok;
    bit got_end;
    int extra;
    int n;
    int end_k;
    n = fr.size();
    end_k = DATA_LAT + n - 1 - END_LAG;
    mac_tx_req = 1'b1;
    wait_out(0, 8, ok);
    check("ack_seen", 32'(ok), 32'd1);
    if (!keep_req) mac_tx_req = 1'b0;
    repeat (ready_dly) @(negedge clk);
    frame_ready = 1'b1;
    wait_out(1, 20, ok);
    frame_ready = 1'b0;
    check("data_req_seen", 32'(ok), 32'd1);
    if (!ok) return;
    got_end = 1'b0;
    extra = 0;
    for (int k = 0; k < DATA_LAT + n; k++) begin
      frame_data = (k >= DATA_LAT) ? fr[k - DATA_LAT] : 8'($urandom);
      frame_end  = (k == end_k);
      @(negedge clk);
      if (mac_tx_ack) extra++;
      if (mac_send_end) got_end = 1'b1;
    end
    frame_end  = 1'b0;
    frame_data = 8'($urandom);
    for (int t = 0; t < 200 && !got_end; t++) begin
      @(negedge clk);
      if (mac_tx_ack) extra++;
      if (mac_send_end) got_end = 1'b1;
    end
    check("send_end_seen", 32'(got_end), 32'd1);
    check("no_ack_before_send_end", extra, 0);
  endtask

  task automatic rand_frame(input int n, output logic [7:0] fr[$]);
    fr = {};
    for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
  endtask

  task automatic reset_test();
    logic [7:0] fr[$];
    bit ok;
    int bad;
    rand_frame(40, fr);
    mon_en = 1'b0;
    mac_tx_req = 1'b1;
    wait_out(0, 8, ok);
    mac_tx_req = 1'b0;
    frame_ready = 1'b1;
    wait_out(1, 20, ok);
    frame_ready = 1'b0;
    check("rst_data_req_seen", 32'(ok), 32'd1);
    for (int k = 0; k <= DATA_LAT + 20; k++) begin
      frame_data = (k >= DATA_LAT) ? fr[k - DATA_LAT] : 8'h00;
      if (k == DATA_LAT + 20) begin
        check("tx_en_before_reset", 32'(gmii_tx_en), 32'd1);
        rstn = 1'b0;
      end
      @(negedge clk);
    end
    check("outputs_after_reset",
          {21'h0, gmii_tx_en, gmii_txd, mac_tx_ack, mac_data_req, mac_send_end}, 32'h0);
    rstn = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      frame_data = (k < 19) ? fr[21 + k] : 8'h00;
      frame_end  = (k == 18 - END_LAG);
      @(negedge clk);
      if (gmii_tx_en || mac_send_end) bad++;
    end
    frame_end = 1'b0;
    check("no_fcs_or_send_end_after_reset", bad, 0);
    mon_en = 1'b1;
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    bit ok;
    int bad;
    build_crc_tab();

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {21'h0, gmii_tx_en, gmii_txd, mac_tx_ack, mac_data_req, mac_send_end}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // 60-byte frame.
    rand_frame(60, fr);
    push_expect(fr);
    run_frame(fr, 1, 1'b0);

    // "123456789" known-answer FCS.
    fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`ifdef MAC_TX_PAD_EN
    push_expect(fr);
`else
    push_preamble();
    foreach (fr[i]) exp_q.push_back(fr[i]);
    exp_q.push_back(8'h26);
    exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4);
    exp_q.push_back(8'hCB);
    exp_len_q.push_back(21);
`endif
    run_frame(fr, 0, 1'b0);

    // Ready never comes: timeout back to IDLE, then a fresh request.
    repeat (3) @(negedge clk);
    mac_tx_req = 1'b1;
    wait_out(0, 8, ok);
    check("timeout_ack_seen", 32'(ok), 32'd1);
    mac_tx_req = 1'b0;
    bad = 0;
    repeat (TIMEOUT + 1) begin
      @(negedge clk);
      if (gmii_tx_en || mac_send_end || mac_data_req || mac_tx_ack) bad++;
    end
    check("timeout_quiet", bad, 0);
    rand_frame(33, fr);
    push_expect(fr);
    mac_tx_req = 1'b1;
    wait_out(0, 2, ok);
    check("ack_within_2_after_timeout", 32'(ok), 32'd1);
    mac_tx_req = 1'b0;
    if (ok) begin
      frame_ready = 1'b1;
      wait_out(1, 20, ok);
      frame_ready = 1'b0;
      for (int k = 0; k < DATA_LAT + 33; k++) begin
        frame_data = (k >= DATA_LAT) ? fr[k - DATA_LAT] : 8'h00;
        frame_end  = (k == DATA_LAT + 32 - END_LAG);
        @(negedge clk);
      end
      frame_end = 1'b0;
      wait_out(2, 200, ok);
      check("timeout_followup_send_end", 32'(ok), 32'd1);
    end

    // Request held high across a whole frame; next ack only after send_end.
    rand_frame(25, fr);
    push_expect(fr);
    run_frame(fr, 2, 1'b1);
    rand_frame(17, fr);
    push_expect(fr);
    run_frame(fr, 0, 1'b0);

    // 20-byte frame (padded to 60 when padding is built in).
    rand_frame(20, fr);
    push_expect(fr);
    run_frame(fr, 3, 1'b0);

    // Single-byte frame: frame_end arrives before DATA begins.
    rand_frame(1, fr);
    push_expect(fr);
    run_frame(fr, 0, 1'b0);

    // Over-length frame is truncated at MAX_FRAME bytes.
    rand_frame(MAX_FRAME + 6, fr);
    push_expect(fr);
    run_frame(fr, 1, 1'b0);

    // Reset in the middle of DATA.
    reset_test();

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      rand_frame($urandom_range(1, 80), fr);
      push_expect(fr);
      run_frame(fr, $urandom_range(0, 5), 1'b0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("lengths_drained", exp_len_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mac_tx.md
Name: mac_tx

Overview:
- Ethernet MAC transmit stage directly downstream of the IP transmit block (and the ARP transmit block through the same mux).
- Accepts a pre-built frame byte stream: dest MAC, source MAC, type and payload.
- Prepends preamble/SFD, appends the IEEE 802.3 FCS and enforces the inter-frame gap.
- Drives the GMII TX pins.
- Provides the mac_tx_ack / mac_data_req / mac_send_end handshake that the IP layer waits on.

Parameters:
- DATA_LAT, 2: cycles from the mac_data_req pulse to frame byte 0 being valid on frame_data. Legal range 1..7.
- END_LAG, 1: cycles from the frame_end pulse to the final frame byte being valid on frame_data. Legal range 0..3.
- IFG_CYCLES, 12: idle cycles after the last FCS byte.
- MAX_FRAME, 1514: maximum frame bytes before FCS.
- TIMEOUT, 16'hffff: wait-for-ready timeout in cycles.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- mac_tx_req  in  1  level request from the upper-layer mux.
- mac_tx_ack  out  1  one-cycle acceptance pulse.
- frame_ready  in  1  upper layer has the frame ready (ip_tx_ready).
- frame_data  in  8  frame byte stream (ip_tx_data).
- frame_end  in  1  one-cycle end marker (ip_tx_end).
- mac_data_req  out  1  one-cycle pulse that starts the upper-layer byte stream.
- mac_send_end  out  1  one-cycle pulse when the frame and the IFG are complete.
- gmii_txd  out  8  GMII transmit data, registered.
- gmii_tx_en  out  1  GMII transmit enable, registered.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and the CRC register is 32'hffffffff.
- A reset asserted mid-frame drops gmii_tx_en on the next edge; no FCS and no mac_send_end are produced.

FSM states: IDLE, ACK, WAIT_READY, PREAMBLE, DATA, FCS, IFG, END.
- IDLE: mac_tx_req=1 moves to ACK. mac_tx_ack pulses high for exactly the one cycle spent in ACK; ACK then moves to WAIT_READY.
- WAIT_READY: frame_ready=1 moves to PREAMBLE. Otherwise a timeout counter increments; at TIMEOUT the FSM returns to IDLE with no GMII activity and no mac_send_end. The counter clears outside WAIT_READY.
- PREAMBLE: 8 cycles on GMII, with gmii_tx_en=1.
  - gmii_txd carries 8'h55 seven times, then 8'hD5 (the SFD).
  - mac_data_req pulses once at the preamble index that makes frame byte 0 (sampled DATA_LAT cycles after the pulse) appear on gmii_txd the cycle immediately after the SFD.
- DATA: gmii_txd <= frame_data each cycle, so GMII lags frame_data by one register stage.
  - An 11-bit byte counter counts frame bytes.
  - When frame_end is seen, exactly END_LAG further cycles of data follow before FCS; simultaneous frame_end and final byte is allowed when END_LAG=0.
  - If the counter reaches MAX_FRAME without frame_end, the frame is truncated at MAX_FRAME bytes and FCS follows.
- FCS: 4 cycles with gmii_tx_en=1.
  - The CRC-32 uses reflected poly 32'hEDB88320 and init 32'hffffffff, updated per byte, LSB-first bit order.
  - It covers every frame byte (and pad bytes) but not the preamble/SFD.
  - The FCS sent is ~crc, least-significant byte first.
- IFG: gmii_tx_en=0 and gmii_txd=0 for IFG_CYCLES cycles.
- END: mac_send_end=1 for one cycle, then IDLE. A new request is acknowledged no earlier than the cycle after END.
- Request handling:
  - mac_tx_req asserted outside IDLE is ignored until IDLE is re-entered.
  - A request that is still high in IDLE is accepted then.
- Counters saturate and never wrap inside a frame. The CRC register is reinitialised in ACK.

Optional Feature:
- Macro: MAC_TX_PAD_EN.
- When defined, frames shorter than 60 bytes (before FCS) are zero-padded to 60 bytes after the final frame byte. The CRC includes the pad bytes, and frame_data is ignored during padding.
- When undefined, frames are sent at their received length, and the padding logic and its comparator are absent.

Test Plan:
1. req, then ready, then a 60-byte frame (DATA_LAT=2, END_LAG=1).
   - GMII shows 7x 8'h55, then 8'hD5, then the 60 bytes in order, then 4 FCS bytes.
   - gmii_tx_en is high for exactly 72 cycles, followed by 12 low cycles, then one mac_send_end pulse.
2. Frame bytes are the ASCII string "123456789" (9 bytes, MAC_TX_PAD_EN off). FCS on GMII = 8'h26, 8'h39, 8'hF4, 8'hCB.
3. req acked but frame_ready held low.
   - After 65535 cycles the FSM is back in IDLE, with gmii_tx_en never high and no mac_send_end.
   - A following req is acked within 2 cycles.
4. mac_tx_req held high through a whole frame.
   - The second mac_tx_ack occurs only after mac_send_end.
   - At least 12 idle cycles separate the two frames on GMII.
5. rstn pulsed low during byte 20 of DATA. gmii_tx_en=0 on the next edge, all outputs are 0, and no FCS or mac_send_end is produced.
6. 20-byte frame.
   - With MAC_TX_PAD_EN: 20 bytes, 40x 8'h00, then FCS computed over all 60 bytes.
   - Without it: 20 bytes then FCS (24 bytes after the SFD).
